// File: rtl/fwrisc_mem_responder.sv
// fwrisc_mem_responder: word-organised RAM target for the FWRISC data bus with byte-strobed writes.
// Latency: ready asserts WAIT_STATES+1 cycles after valid is first sampled; one transaction per WAIT_STATES+2 cycles.
// Backpressure: initiator holds valid until ready; dropping valid during wait states aborts with a one-cycle err pulse.
// Optional macro FWRISC_MEM_RESPONDER_RAND_WAIT_EN adds 0..3 extra LFSR-driven wait states per transaction.
module fwrisc_mem_responder #(
  parameter int    ADDR_WIDTH  = 14,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstb,
  input  logic        write,
  input  logic        valid,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  // Counter load for the fixed part of the stall; WAIT_STATES==0 never enters WAIT
  // unless the random extension asks for it.
  localparam logic [3:0] WS_M1 = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Parameter sanity: the wait counter is only 4 bits and the word index must
  // leave room for the ignored upper address bits.
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("fwrisc_mem_responder: WAIT_STATES must be in 0..15");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
    $error("fwrisc_mem_responder: ADDR_WIDTH must be in 1..29");
  end

  logic [31:0] ram [0:(1 << ADDR_WIDTH) - 1];

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;
  logic [3:0]              cnt_nxt;
  logic                    err_q;
  logic                    abort;
  logic                    capture;
  logic                    go_wait;
  logic [3:0]              load_val;
  logic [ADDR_WIDTH-1:0]   addr_idx;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [ADDR_WIDTH-1:0]   req_idx;
  logic [31:0]             req_wdata;
  logic [3:0]              req_wstb;
  logic                    req_write;
  logic [31:0]             rd_q;
  logic                    unused_addr_bits;

  // Byte offset and bits above the RAM depth alias onto the same word.
  assign addr_idx         = addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
  assign capture          = (state == S_IDLE) && valid;

`ifdef FWRISC_MEM_RESPONDER_RAND_WAIT_EN
  logic [15:0] lfsr;
  logic [4:0]  load_sum;

  // Free-running Fibonacci LFSR, taps 16,14,13,11.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Stall length = fixed wait states plus LFSR[1:0], saturated to the counter range.
  always_comb begin
    load_sum = {1'b0, WS_M1} + {3'b000, lfsr[1:0]};
    if (WAIT_STATES == 0) begin
      go_wait  = (lfsr[1:0] != 2'b00);
      load_val = {2'b00, lfsr[1:0] - 2'd1};
    end else begin
      go_wait  = 1'b1;
      load_val = (load_sum > 5'd15) ? 4'hF : load_sum[3:0];
    end
  end
`else
  // Fixed stall length.
  always_comb begin
    go_wait  = (WAIT_STATES != 0);
    load_val = WS_M1;
  end
`endif

  // State register, wait counter and registered abort pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      err_q <= abort;
    end
  end

  // Next-state logic: IDLE captures, WAIT counts down while valid holds, RESP lasts one cycle.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (valid) begin
          if (go_wait) begin
            state_nxt = S_WAIT;
            cnt_nxt   = load_val;
          end else begin
            state_nxt = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (!valid) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd0) begin
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Outputs decoded from state; rdata is forced to zero outside a read response.
  always_comb begin
    ready = (state == S_RESP);
    rdata = ((state == S_RESP) && !req_write) ? rd_q : 32'h0;
    abort = (state == S_WAIT) && !valid;
    err   = err_q;
  end

  // Request registers: inputs are frozen at capture and ignored afterwards.
  always_ff @(posedge clock) begin
    if (!reset && capture) begin
      req_idx   <= addr_idx;
      req_wdata <= wdata;
      req_wstb  <= wstb;
      req_write <= write;
    end
  end

  // While idle the read port follows the live address so a zero-wait read has
  // its data in the response cycle; afterwards it tracks the captured index.
  assign rd_idx = (state == S_IDLE) ? addr_idx : req_idx;

  // Synchronous read port.
  always_ff @(posedge clock) begin
    rd_q <= ram[rd_idx];
  end

  // Byte-strobed write committed at the end of the response cycle; a reset in that
  // cycle suppresses it.
  always_ff @(posedge clock) begin
    if (!reset && (state == S_RESP) && req_write) begin
      for (int b = 0; b < 4; b++) begin
        if (req_wstb[b]) begin
          ram[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_fwrisc_mem_responder.sv
// Bench for fwrisc_mem_responder: three instances (WAIT_STATES 2, 0, 3) share clock and reset.
// A transaction-schedule model predicts ready/err/rdata every cycle; directed vectors add literal checks.
module tb_fwrisc_mem_responder;

  logic             clock;
  logic             reset;
  logic [2:0][31:0] addr_v;
  logic [2:0][31:0] wdata_v;
  logic [2:0][3:0]  wstb_v;
  logic [2:0]       write_v;
  logic [2:0]       valid_v;
  logic [2:0][31:0] rdata_v;
  logic [2:0]       ready_v;
  logic [2:0]       err_v;

  int errors = 0;
  int checks = 0;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_dut
    fwrisc_mem_responder #(
      .ADDR_WIDTH (14),
      .WAIT_STATES((g == 0) ? 2 : ((g == 1) ? 0 : 3)),
      .INIT_FILE  ("")
    ) u_dut (
      .clock(clock),
      .reset(reset),
      .addr (addr_v[g]),
      .wdata(wdata_v[g]),
      .wstb (wstb_v[g]),
      .write(write_v[g]),
      .valid(valid_v[g]),
      .rdata(rdata_v[g]),
      .ready(ready_v[g]),
      .err  (err_v[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, i, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A request captured at the edge closing period n answers in period n+W+1; any
  // edge in between that sees valid low aborts it (err in the following period).
  logic [31:0] mm [int];
  bit          pend [3];
  int          due  [3];
  logic [13:0] m_idx [3];
  bit          m_wr  [3];
  logic [31:0] m_wd  [3];
  logic [3:0]  m_stb [3];
  bit          e_ready [3];
  bit          e_err   [3];
  bit          e_known [3];
  logic [31:0] e_rdata [3];
  int          per = 0;
  bit          mdl_on = 0;

  task automatic mdl_write(input int i);
    int key;
    logic [31:0] w;
    key = i * 65536 + int'(m_idx[i]);
    w = mm.exists(key) ? mm[key] : 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (m_stb[i][b]) w[8*b +: 8] = m_wd[i][8*b +: 8];
    end
    mm[key] = w;
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      e_err[i] = 1'b0;
      if (reset) begin
        pend[i] = 1'b0;
      end else if (pend[i]) begin
        if (per == due[i]) begin
          if (m_wr[i]) mdl_write(i);
          pend[i] = 1'b0;
        end else if (!valid_v[i]) begin
          e_err[i] = 1'b1;
          pend[i]  = 1'b0;
        end
      end else if (valid_v[i]) begin
        m_idx[i] = addr_v[i][15:2];
        m_wr[i]  = write_v[i];
        m_wd[i]  = wdata_v[i];
        m_stb[i] = wstb_v[i];
        due[i]   = per + ws_of(i) + 1;
        pend[i]  = 1'b1;
      end
      e_ready[i] = pend[i] && (due[i] == per + 1);
      e_rdata[i] = 32'h0;
      e_known[i] = 1'b1;
      if (e_ready[i] && !m_wr[i]) begin
        if (mm.exists(i * 65536 + int'(m_idx[i]))) e_rdata[i] = mm[i * 65536 + int'(m_idx[i])];
        else e_known[i] = 1'b0;
      end
    end
    if (reset) mdl_on = 1'b1;
    per++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (mdl_on) begin
      for (int i = 0; i < 3; i++) begin
        chk("model_ready", i, 32'(ready_v[i]), 32'(e_ready[i]));
        chk("model_err", i, 32'(err_v[i]), 32'(e_err[i]));
        if (e_known[i]) chk("model_rdata", i, rdata_v[i], e_rdata[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input int i, input logic [31:0] a, input logic wr, input logic [31:0] d,
                      input logic [3:0] s, output int lat, output logic [31:0] rd);
    @(negedge clock);
    addr_v[i]  = a;
    write_v[i] = wr;
    wdata_v[i] = d;
    wstb_v[i]  = s;
    valid_v[i] = 1'b1;
    lat = 0;
    rd  = 32'h0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (ready_v[i]) begin
        lat = k;
        rd  = rdata_v[i];
        break;
      end
    end
    valid_v[i] = 1'b0;
    if (lat == 0) chk("ready_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic count_ready(input int i, input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      if (ready_v[i]) cnt++;
    end
  endtask

  initial begin
    int lat;
    int rc;
    logic [31:0] rd;

    reset   = 1'b1;
    addr_v  = '0;
    wdata_v = '0;
    wstb_v  = '0;
    write_v = '0;
    valid_v = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", i, 32'(ready_v[i]), 32'd0);
      chk("reset_err", i, 32'(err_v[i]), 32'd0);
      chk("reset_rdata", i, rdata_v[i], 32'h0);
    end

    // WAIT_STATES=2: full write then read-back
    xact(0, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, lat, rd);
    chk("w2_write_latency", 0, 32'(lat), 32'd3);
    chk("w2_write_rdata_zero", 0, rd, 32'h0);
    xact(0, 32'h10, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("w2_read_latency", 0, 32'(lat), 32'd3);
    chk("w2_read_data", 0, rd, 32'hDEADBEEF);

    // Byte strobes
    xact(0, 32'h20, 1'b1, 32'h11223344, 4'hF, lat, rd);
    xact(0, 32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, lat, rd);
    xact(0, 32'h20, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("strobe_merge", 0, rd, 32'h11BB33DD);

    // WAIT_STATES=0: preload, then back-to-back reads with valid held high
    xact(1, 32'h0, 1'b1, 32'hCAFE0000, 4'hF, lat, rd);
    chk("w0_write_latency", 1, 32'(lat), 32'd1);
    xact(1, 32'h4, 1'b1, 32'h0000F00D, 4'hF, lat, rd);
    @(negedge clock);
    addr_v[1] = 32'h0; write_v[1] = 1'b0; valid_v[1] = 1'b1;
    @(negedge clock);
    chk("b2b_ready_c1", 1, 32'(ready_v[1]), 32'd1);
    chk("b2b_rdata_c1", 1, rdata_v[1], 32'hCAFE0000);
    addr_v[1] = 32'h4;
    @(negedge clock);
    chk("b2b_ready_c2", 1, 32'(ready_v[1]), 32'd0);
    chk("b2b_rdata_c2", 1, rdata_v[1], 32'h0);
    @(negedge clock);
    chk("b2b_ready_c3", 1, 32'(ready_v[1]), 32'd1);
    chk("b2b_rdata_c3", 1, rdata_v[1], 32'h0000F00D);
    valid_v[1] = 1'b0;

    // Abort with WAIT_STATES=3
    xact(2, 32'h40, 1'b1, 32'h12345678, 4'hF, lat, rd);
    chk("w3_write_latency", 2, 32'(lat), 32'd4);
    @(negedge clock);
    addr_v[2] = 32'h40; write_v[2] = 1'b1; wdata_v[2] = 32'hFFFFFFFF; wstb_v[2] = 4'hF; valid_v[2] = 1'b1;
    @(negedge clock);
    valid_v[2] = 1'b0;
    @(negedge clock);
    chk("abort_err_pulse", 2, 32'(err_v[2]), 32'd1);
    chk("abort_no_ready", 2, 32'(ready_v[2]), 32'd0);
    @(negedge clock);
    chk("abort_err_one_cycle", 2, 32'(err_v[2]), 32'd0);
    count_ready(2, 6, rc);
    chk("abort_ready_count", 2, 32'(rc), 32'd0);
    xact(2, 32'h40, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("abort_word_kept", 2, rd, 32'h12345678);

    // Aliasing and empty strobe
    xact(0, 32'h00010008, 1'b1, 32'h5A5A1234, 4'hF, lat, rd);
    xact(0, 32'h00000008, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("alias_read", 0, rd, 32'h5A5A1234);
    xact(0, 32'hFFFF000B, 1'b1, 32'h00000000, 4'h0, lat, rd);
    chk("nostrobe_latency", 0, 32'(lat), 32'd3);
    xact(0, 32'h0000000A, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("nostrobe_kept", 0, rd, 32'h5A5A1234);

    // Reset during WAIT of a write
    xact(0, 32'h30, 1'b1, 32'h0BADF00D, 4'hF, lat, rd);
    @(negedge clock);
    addr_v[0] = 32'h30; write_v[0] = 1'b1; wdata_v[0] = 32'hFFFFFFFF; wstb_v[0] = 4'hF; valid_v[0] = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    valid_v[0] = 1'b0;
    chk("rst_ready_low", 0, 32'(ready_v[0]), 32'd0);
    count_ready(0, 6, rc);
    chk("rst_ready_count", 0, 32'(rc), 32'd0);
    xact(0, 32'h30, 1'b0, 32'h0, 4'h0, lat, rd);
    chk("rst_read_latency", 0, 32'(lat), 32'd3);
    chk("rst_word_kept", 0, rd, 32'h0BADF00D);

    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
